silence_detector_mc: RTL and testbench
======================================

// Module: silence_detector_mc
// PURPOSE
//  Multi-channel silence/sleep detector for the audio path. Inspects each sample frame
//  (NCH channels) on an in_valid strobe. Asserts sleep_status after SLEEP_CNT consecutive
//  silent frames, and deasserts it only after WAKE_CNT consecutive non-silent frames.
//  Sits after the input deserialiser; sleep_status gates the downstream DSP/DAC power-down.
// PARAMETERS
//  NCH       2    number of channels per frame
//  DW        16   sample width, two's complement
//  THRESH    0    silent if |sample| <= THRESH; value range 0..2^(DW-1)-1
//  SLEEP_CNT 800  consecutive silent frames needed to enter sleep; >=1
//  WAKE_CNT  1    consecutive non-silent frames needed to leave sleep; >=1
//  CW        $clog2(SLEEP_CNT+1)  counter width (derived, localparam)
// PORTS
//  Clk          in   1       single clock, all logic rising-edge
//  Reset        in   1       synchronous, active-high
//  in_valid     in   1       frame strobe; one frame per high cycle
//  in_data      in   NCH*DW  packed frame; ch0 in [DW-1:0]
//  sleep_status out  1       1 = asleep (SLEEP or WAKING)
//  sleep_ch     out  NCH     per-channel silence flag
//  silent_cnt   out  CW      global run counter (debug)
//  out_valid    out  1       (SILENCE_MUTE_EN only) delayed in_valid
//  out_data     out  NCH*DW  (SILENCE_MUTE_EN only) delayed, muted frame
// BEHAVIOUR
//  - One clock, Clk. Reset is synchronous and active-high, port Reset. Reset has priority
//    over in_valid. On reset: state=ACTIVE, sleep_status=0, sleep_ch=0, silent_cnt=0,
//    wake_cnt=0, per-channel counters=0, out_valid=0, out_data=0.
//  - in_valid=0: no state, counter or output changes (out_valid=0 the next cycle).
//  - |x| is computed in DW unsigned bits. Most-negative value -> 2^(DW-1), which is never silent.
//  - A frame is silent iff every channel has |x| <= THRESH.
//  - All outputs are registered. They update on the same edge that samples in_valid
//    (latency 1 cycle from strobe to output).
//  - FSM, advancing only on in_valid:
//    ACTIVE:   silent -> cnt=1; to SLEEP if SLEEP_CNT==1, else COUNTING. non-silent -> stay, cnt=0.
//    COUNTING: silent -> cnt+1; if cnt+1==SLEEP_CNT -> SLEEP. non-silent -> ACTIVE, cnt=0.
//    SLEEP:    silent -> stay, cnt held at SLEEP_CNT (saturated). non-silent -> ACTIVE if
//              WAKE_CNT==1 (cnt=0), else WAKING, wake_cnt=1.
//    WAKING:   non-silent -> wake_cnt+1; if it reaches WAKE_CNT -> ACTIVE, cnt=0, wake_cnt=0.
//              silent -> SLEEP, wake_cnt=0 (cnt stays SLEEP_CNT).
//  - sleep_status = (next state is SLEEP or WAKING). It rises on the edge that samples the
//    SLEEP_CNT-th silent frame. It falls on the edge that samples the WAKE_CNT-th
//    non-silent frame.
//  - sleep_ch[i]: independent saturating counter per channel. Set on that channel's
//    SLEEP_CNT-th consecutive silent sample. Cleared, together with its counter, on any
//    non-silent sample of that channel. No wake hysteresis.
//  - Counters never wrap: they saturate at SLEEP_CNT.
// CONFIGURATION
//  SILENCE_MUTE_EN defined:
//    - out_valid/out_data exist. out_valid = in_valid delayed 1 cycle.
//    - out_data = in_data registered on in_valid, forced to 0 when the sleep_status value
//      from the same edge is 1. out_data is aligned with sleep_status.
//    - out_data holds its value when in_valid=0.
//  SILENCE_MUTE_EN undefined: out_valid/out_data ports and logic absent; the rest is identical.
// TESTING  (bench params NCH=2 DW=16 THRESH=3 SLEEP_CNT=4 WAKE_CNT=2)
//  - Reset with in_valid=1, in_data!=0 -> all outputs 0 the next cycle; state ACTIVE.
//  - 4 frames {L=2,R=-3} -> silent_cnt 1,2,3,4; sleep_status=1 after the 4th strobe;
//    5th frame keeps cnt=4.
//  - 3 silent frames, then {L=4,R=0}, then 4 silent -> no sleep until the 4th frame after
//    the break (cnt 1,2,3,0,1,2,3,4).
//  - Asleep, {L=100,R=0} then silent -> WAKING then SLEEP, sleep_status stays 1.
//    Then two frames {L=100} -> sleep_status=0 after the 2nd.
//  - L=0 x4 with R=500 -> sleep_ch=2'b01, sleep_status=0. L=-32768 -> sleep_ch[0] clears.
//  - SILENCE_MUTE_EN: frames spaced by idle cycles while asleep -> out_valid pulses 1 cycle
//    late, out_data=0. Frame {1000,-1000} that completes a wake -> out_data={1000,-1000}.

Source files
------------

// File: rtl/silence_detector_mc.sv
// Multi-channel silence/sleep detector: frame-level sleep FSM with wake hysteresis plus per-channel silence flags.
// Optional SILENCE_MUTE_EN adds a 1-cycle delayed frame output that is zeroed while asleep.
module silence_detector_mc #(
  parameter int NCH       = 2,
  parameter int DW        = 16,
  parameter int THRESH    = 0,
  parameter int SLEEP_CNT = 800,
  parameter int WAKE_CNT  = 1,
  localparam int CW       = $clog2(SLEEP_CNT + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic              sleep_status,
  output logic [NCH-1:0]    sleep_ch,
  output logic [CW-1:0]     silent_cnt
`ifdef SILENCE_MUTE_EN
  ,
  output logic              out_valid,
  output logic [NCH*DW-1:0] out_data
`endif
);

  localparam int WW = $clog2(WAKE_CNT + 1);

  typedef enum logic [1:0] {ACTIVE, COUNTING, SLEEP, WAKING} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [WW-1:0]   wake_reg, wake_next;
  logic            sleep_reg, sleep_next;
  logic [NCH-1:0]  ch_silent;
  logic            frame_silent;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DW-1:0] sample;
      logic [DW-1:0] mag;
      logic [CW-1:0] ch_cnt_reg;
      logic          flag_reg;

      // Magnitude in DW unsigned bits: the most-negative code maps to 2^(DW-1), never silent.
      assign sample        = in_data[gi*DW +: DW];
      assign mag           = sample[DW-1] ? (~sample + DW'(1)) : sample;
      assign ch_silent[gi] = (mag <= DW'(THRESH));
      assign sleep_ch[gi]  = flag_reg;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          ch_cnt_reg <= '0;
          flag_reg   <= 1'b0;
        end else if (in_valid) begin
          if (ch_silent[gi]) begin
            if (ch_cnt_reg != CW'(SLEEP_CNT))
              ch_cnt_reg <= ch_cnt_reg + CW'(1);
            flag_reg <= (ch_cnt_reg >= CW'(SLEEP_CNT - 1));
          end else begin
            ch_cnt_reg <= '0;
            flag_reg   <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign frame_silent = &ch_silent;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wake_next  = wake_reg;
    if (in_valid) begin
      case (state_reg)
        ACTIVE: begin
          if (frame_silent) begin
            cnt_next   = CW'(1);
            state_next = (SLEEP_CNT == 1) ? SLEEP : COUNTING;
          end else begin
            cnt_next = '0;
          end
        end
        COUNTING: begin
          if (frame_silent) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_next == CW'(SLEEP_CNT))
              state_next = SLEEP;
          end else begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end
        end
        SLEEP: begin
          if (frame_silent) begin
            cnt_next = CW'(SLEEP_CNT);
          end else if (WAKE_CNT == 1) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else begin
            state_next = WAKING;
            wake_next  = WW'(1);
          end
        end
        WAKING: begin
          if (frame_silent) begin
            state_next = SLEEP;
            wake_next  = '0;
          end else begin
            wake_next = wake_reg + WW'(1);
            if (wake_next == WW'(WAKE_CNT)) begin
              state_next = ACTIVE;
              cnt_next   = '0;
              wake_next  = '0;
            end
          end
        end
        default: begin
          state_next = ACTIVE;
          cnt_next   = '0;
          wake_next  = '0;
        end
      endcase
    end
  end

  // Still asleep while waking: power-down only lifts once the wake run completes.
  assign sleep_next = (state_next == SLEEP) || (state_next == WAKING);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ACTIVE;
      cnt_reg   <= '0;
      wake_reg  <= '0;
      sleep_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wake_reg  <= wake_next;
      sleep_reg <= sleep_next;
    end
  end

  assign sleep_status = sleep_reg;
  assign silent_cnt   = cnt_reg;

`ifdef SILENCE_MUTE_EN
  logic              out_valid_reg;
  logic [NCH*DW-1:0] out_data_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid)
        out_data_reg <= sleep_next ? '0 : in_data;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
`endif

endmodule

// File: tb/tb_silence_detector_mc.sv
// Directed self-checking bench for silence_detector_mc (NCH=2 DW=16 THRESH=3 SLEEP_CNT=4 WAKE_CNT=2).
// Mute-path checks compile in when SILENCE_MUTE_EN is defined.
module tb_silence_detector_mc;
  localparam int NCH = 2, DW = 16, THRESH = 3, SLEEP_CNT = 4, WAKE_CNT = 2, CW = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          sleep_status;
  logic [1:0]    sleep_ch;
  logic [CW-1:0] silent_cnt;
`ifdef SILENCE_MUTE_EN
  logic          out_valid;
  logic [31:0]   out_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  silence_detector_mc #(
    .NCH(NCH), .DW(DW), .THRESH(THRESH), .SLEEP_CNT(SLEEP_CNT), .WAKE_CNT(WAKE_CNT)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .sleep_status(sleep_status),
    .sleep_ch(sleep_ch),
    .silent_cnt(silent_cnt)
`ifdef SILENCE_MUTE_EN
    ,
    .out_valid(out_valid),
    .out_data(out_data)
`endif
  );

  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r);
    in_valid = v;
    in_data  = {r, l};
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    $display("t=%0t rst=%0b v=%0b L=%0d R=%0d -> sleep=%0b ch=%b cnt=%0d",
             $time, Reset, v, $signed(l), $signed(r), sleep_status, sleep_ch, silent_cnt);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(1'b0, 16'd0, 16'd0);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, 16'd0, 16'd0);
    step(1'b1, 16'd0, 16'd0);
    Reset = 1'b1;
    step(1'b1, 16'h1234, 16'h5678);
    Reset = 1'b0;
    checks++; if (sleep_status !== 1'b0) begin errors++; $display("FAIL reset_sleep got=%b exp=0", sleep_status); end
    checks++; if (sleep_ch !== 2'b00) begin errors++; $display("FAIL reset_ch got=%b exp=00", sleep_ch); end
    checks++; if (silent_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", silent_cnt); end
`ifdef SILENCE_MUTE_EN
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_odata got=%h exp=0", out_data); end
`endif
    step(1'b1, 16'd0, 16'd0);
    checks++; if (silent_cnt !== 3'd1) begin errors++; $display("FAIL reset_first_cnt got=%0d exp=1", silent_cnt); end
    step(1'b1, 16'd0, 16'd0);
    step(1'b1, 16'd0, 16'd0);
    checks++; if (sleep_ch !== 2'b00 || sleep_status !== 1'b0) begin
      errors++; $display("FAIL reset_ch_cleared got ch=%b sleep=%b exp ch=00 sleep=0", sleep_ch, sleep_status); end
    step(1'b1, 16'd0, 16'd0);
    checks++; if (sleep_ch !== 2'b11 || sleep_status !== 1'b1) begin
      errors++; $display("FAIL reset_4th got ch=%b sleep=%b exp ch=11 sleep=1", sleep_ch, sleep_status); end
  endtask

  task automatic test_sleep_entry();
    int       exp_cnt[5]   = '{1, 2, 3, 4, 4};
    logic     exp_sleep[5] = '{0, 0, 0, 1, 1};
    logic [1:0] exp_ch[5]  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'd2, -16'sd3);
      checks++; if (silent_cnt !== CW'(exp_cnt[i])) begin errors++; $display("FAIL entry_cnt[%0d] got=%0d exp=%0d", i, silent_cnt, exp_cnt[i]); end
      checks++; if (sleep_status !== exp_sleep[i]) begin errors++; $display("FAIL entry_sleep[%0d] got=%b exp=%b", i, sleep_status, exp_sleep[i]); end
      checks++; if (sleep_ch !== exp_ch[i]) begin errors++; $display("FAIL entry_ch[%0d] got=%b exp=%b", i, sleep_ch, exp_ch[i]); end
    end
    step(1'b0, 16'd500, 16'd500);
    checks++; if (silent_cnt !== 3'd4 || sleep_status !== 1'b1) begin
      errors++; $display("FAIL entry_idle got cnt=%0d sleep=%b exp cnt=4 sleep=1", silent_cnt, sleep_status); end
  endtask

  task automatic test_break();
    int       exp_cnt[8]   = '{1, 2, 3, 0, 1, 2, 3, 4};
    logic [1:0] exp_ch[8]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 3) ? 16'd4 : 16'd0, 16'd0);
      checks++; if (silent_cnt !== CW'(exp_cnt[i])) begin errors++; $display("FAIL break_cnt[%0d] got=%0d exp=%0d", i, silent_cnt, exp_cnt[i]); end
      checks++; if (sleep_status !== (i == 7)) begin errors++; $display("FAIL break_sleep[%0d] got=%b exp=%b", i, sleep_status, (i == 7)); end
      checks++; if (sleep_ch !== exp_ch[i]) begin errors++; $display("FAIL break_ch[%0d] got=%b exp=%b", i, sleep_ch, exp_ch[i]); end
    end
  endtask

  task automatic test_wake();
    logic [15:0] l_seq[4]  = '{16'd100, 16'd0, 16'd100, 16'd100};
    logic     exp_sleep[4] = '{1, 1, 1, 0};
    int       exp_cnt[4]   = '{4, 4, 4, 0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, l_seq[i], 16'd0);
      checks++; if (sleep_status !== exp_sleep[i]) begin errors++; $display("FAIL wake_sleep[%0d] got=%b exp=%b", i, sleep_status, exp_sleep[i]); end
      checks++; if (silent_cnt !== CW'(exp_cnt[i])) begin errors++; $display("FAIL wake_cnt[%0d] got=%0d exp=%0d", i, silent_cnt, exp_cnt[i]); end
      checks++; if (sleep_ch !== 2'b10) begin errors++; $display("FAIL wake_ch[%0d] got=%b exp=10", i, sleep_ch); end
    end
  endtask

  task automatic test_per_channel();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'd0, 16'd500);
      checks++; if (sleep_ch !== ((i == 3) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL chan_ch[%0d] got=%b exp=%b", i, sleep_ch, ((i == 3) ? 2'b01 : 2'b00)); end
      checks++; if (sleep_status !== 1'b0 || silent_cnt !== 3'd0) begin
        errors++; $display("FAIL chan_global[%0d] got sleep=%b cnt=%0d exp sleep=0 cnt=0", i, sleep_status, silent_cnt); end
    end
    step(1'b1, 16'h8000, 16'd500);
    checks++; if (sleep_ch !== 2'b00) begin errors++; $display("FAIL chan_minneg got=%b exp=00", sleep_ch); end
    step(1'b1, 16'h8000, 16'd0);
    checks++; if (silent_cnt !== 3'd0) begin errors++; $display("FAIL chan_minneg_cnt got=%0d exp=0", silent_cnt); end
  endtask

`ifdef SILENCE_MUTE_EN
  task automatic test_mute();
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_d = (i == 3) ? 32'd0 : 32'hFFFD0002;
      step(1'b1, 16'd2, 16'hFFFD);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mute_ovalid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp_d) begin errors++; $display("FAIL mute_odata[%0d] got=%h exp=%h", i, out_data, exp_d); end
      step(1'b0, 16'd7, 16'd7);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mute_idle_ovalid[%0d] got=%b exp=0", i, out_valid); end
      checks++; if (out_data !== exp_d) begin errors++; $display("FAIL mute_hold[%0d] got=%h exp=%h", i, out_data, exp_d); end
    end
    step(1'b1, 16'd1000, 16'hFC18);
    checks++; if (out_data !== 32'd0 || sleep_status !== 1'b1) begin
      errors++; $display("FAIL mute_waking got data=%h sleep=%b exp data=0 sleep=1", out_data, sleep_status); end
    step(1'b0, 16'd0, 16'd0);
    step(1'b1, 16'd1000, 16'hFC18);
    checks++; if (out_data !== 32'hFC1803E8 || sleep_status !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mute_woken got data=%h sleep=%b ov=%b exp data=fc1803e8 sleep=0 ov=1", out_data, sleep_status, out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_sleep_entry();
    test_break();
    test_wake();
    test_per_channel();
`ifdef SILENCE_MUTE_EN
    test_mute();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
